// File: rtl/lagarto_fp_mantissa_mult_pipe.sv
// Pipelined unsigned mantissa multiplier: each stage multiplies src1 by one src2
// chunk and adds it into a running accumulator, with tag, sticky, lock and flush.
module lagarto_fp_mantissa_mult_pipe #(
  parameter int MANTISSA = 53,
  parameter int STAGES   = 3,
  parameter int TAG_W    = 8
) (
  input  logic                    clk_i,
  input  logic                    rstn_i,
  input  logic                    lock_i,
  input  logic                    flush_i,
  input  logic                    op_valid_i,
  input  logic [TAG_W-1:0]        tag_i,
  input  logic [MANTISSA-1:0]     src1_i,
  input  logic [MANTISSA-1:0]     src2_i,
  output logic                    result_valid_o,
  output logic [TAG_W-1:0]        result_tag_o,
  output logic [2*MANTISSA-1:0]   result_data_o,
  output logic                    result_sticky_o,
  output logic                    busy_o
);

  localparam int CHUNK = (MANTISSA + STAGES - 1) / STAGES;
  localparam int PW    = 2 * MANTISSA;
  localparam int PPW   = MANTISSA + CHUNK;

  logic [STAGES-1:0]                valid_q, valid_d;
  logic [STAGES-1:0][TAG_W-1:0]     tag_q, tag_d;
  logic [STAGES-1:0][MANTISSA-1:0]  src1_q, src1_d;
  logic [STAGES-1:0][MANTISSA-1:0]  src2_q, src2_d;
  logic [STAGES-1:0][PW-1:0]        acc_q, acc_d;

  // Stage k's input view: index 0 is the issue port, index k>0 is stage k-1.
  logic [STAGES-1:0]                in_vld;
  logic [STAGES-1:0][TAG_W-1:0]     in_tag;
  logic [STAGES-1:0][MANTISSA-1:0]  in_src1;
  logic [STAGES-1:0][MANTISSA-1:0]  in_src2;
  logic [STAGES-1:0][PW-1:0]        in_acc;
  logic [CHUNK-1:0]                 chunk;
  logic [PPW-1:0]                   pp;

  always_comb begin
    in_vld     = '0;
    in_tag     = '0;
    in_src1    = '0;
    in_src2    = '0;
    in_acc     = '0;
    in_vld[0]  = op_valid_i;
    in_tag[0]  = tag_i;
    in_src1[0] = src1_i;
    in_src2[0] = src2_i;
    for (int k = 1; k < STAGES; k++) begin
      in_vld[k]  = valid_q[k-1];
      in_tag[k]  = tag_q[k-1];
      in_src1[k] = src1_q[k-1];
      in_src2[k] = src2_q[k-1];
      in_acc[k]  = acc_q[k-1];
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    src1_d  = src1_q;
    src2_d  = src2_q;
    acc_d   = acc_q;
    chunk   = '0;
    pp      = '0;
    if (flush_i) begin
      valid_d = '0;
      tag_d   = '0;
      src1_d  = '0;
      src2_d  = '0;
      acc_d   = '0;
    end else if (!lock_i) begin
      for (int k = 0; k < STAGES; k++) begin
        // Chunks past the MSB shift out to zero, covering a narrow last chunk.
        chunk      = CHUNK'(in_src2[k] >> (k * CHUNK));
        pp         = PPW'(in_src1[k]) * PPW'(chunk);
        valid_d[k] = in_vld[k];
        if (in_vld[k]) begin
          tag_d[k]  = in_tag[k];
          src1_d[k] = in_src1[k];
          src2_d[k] = in_src2[k];
          acc_d[k]  = in_acc[k] + (PW'(pp) << (k * CHUNK));
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      valid_q <= '0;
      tag_q   <= '0;
      src1_q  <= '0;
      src2_q  <= '0;
      acc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      src1_q  <= src1_d;
      src2_q  <= src2_d;
      acc_q   <= acc_d;
    end
  end

  // Final-stage operands have no consumer; synthesis trims them.
  logic unused_final_src;
  assign unused_final_src = ^{src1_q[STAGES-1], src2_q[STAGES-1]};

  assign result_valid_o  = valid_q[STAGES-1];
  assign result_tag_o    = result_valid_o ? tag_q[STAGES-1] : '0;
  assign result_data_o   = result_valid_o ? acc_q[STAGES-1] : '0;
  assign result_sticky_o = result_valid_o & (|acc_q[STAGES-1][MANTISSA-3:0]);
  assign busy_o          = |valid_q;

endmodule

// File: tb/tb_lagarto_fp_mantissa_mult_pipe.sv
// Self-checking bench for lagarto_fp_mantissa_mult_pipe: main 53x3 instance plus
// a parameter sweep of smaller/deeper configurations against a plain-arithmetic model.
module tb_lagarto_fp_mantissa_mult_pipe;

  localparam int M  = 53;
  localparam int S  = 3;
  localparam int TW = 8;
  localparam int NSW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rstn, lock, flush, op_valid;
  logic [TW-1:0]  tag;
  logic [M-1:0]   src1, src2;
  logic           rv, rsticky, busy;
  logic [TW-1:0]  rtag;
  logic [2*M-1:0] rdata;

  int err = 0;
  int chk = 0;

  lagarto_fp_mantissa_mult_pipe #(.MANTISSA(M), .STAGES(S), .TAG_W(TW)) dut (
    .clk_i(clk), .rstn_i(rstn), .lock_i(lock), .flush_i(flush),
    .op_valid_i(op_valid), .tag_i(tag), .src1_i(src1), .src2_i(src2),
    .result_valid_o(rv), .result_tag_o(rtag), .result_data_o(rdata),
    .result_sticky_o(rsticky), .busy_o(busy)
  );

  function automatic int sw_m(input int i);
    return (i == 0) ? 11 : (i == 1) ? 24 : 53;
  endfunction
  function automatic int sw_s(input int i);
    return (i == 0) ? 1 : (i == 1) ? 2 : 4;
  endfunction

  logic          sw_valid;
  logic [TW-1:0] sw_tag;
  logic [63:0]   sw_src1, sw_src2;
  logic          sw_v[NSW];
  logic          sw_st[NSW];
  logic          sw_b[NSW];
  logic [TW-1:0] sw_t[NSW];
  logic [127:0]  sw_d[NSW];

  for (genvar g = 0; g < NSW; g++) begin : g_sw
    localparam int GM = sw_m(g);
    localparam int GS = sw_s(g);
    logic [2*GM-1:0] d;
    assign sw_d[g] = 128'(d);
    lagarto_fp_mantissa_mult_pipe #(.MANTISSA(GM), .STAGES(GS), .TAG_W(TW)) u (
      .clk_i(clk), .rstn_i(rstn), .lock_i(1'b0), .flush_i(1'b0),
      .op_valid_i(sw_valid), .tag_i(sw_tag),
      .src1_i(sw_src1[GM-1:0]), .src2_i(sw_src2[GM-1:0]),
      .result_valid_o(sw_v[g]), .result_tag_o(sw_t[g]), .result_data_o(d),
      .result_sticky_o(sw_st[g]), .busy_o(sw_b[g])
    );
  end

  // Reference: exact product of the m-bit operands, sticky = OR of bits [m-3:0].
  function automatic logic [127:0] ref_prod(input logic [127:0] a, input logic [127:0] b,
                                            input int m);
    logic [127:0] mask;
    mask = (128'(1) << m) - 128'(1);
    return (a & mask) * (b & mask);
  endfunction
  function automatic logic ref_sticky(input logic [127:0] p, input int m);
    logic [127:0] mask;
    mask = (128'(1) << (m - 2)) - 128'(1);
    return |(p & mask);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    repeat (2) step();
    chk++; if (rv !== 1'b0)    begin err++; $display("FAIL reset_valid got=%0b exp=0", rv); end
    chk++; if (rtag !== '0)    begin err++; $display("FAIL reset_tag got=%h exp=0", rtag); end
    chk++; if (rdata !== '0)   begin err++; $display("FAIL reset_data got=%h exp=0", rdata); end
    chk++; if (rsticky !== 1'b0) begin err++; $display("FAIL reset_sticky got=%0b exp=0", rsticky); end
    chk++; if (busy !== 1'b0)  begin err++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    rstn = 1'b1;
    step();
    chk++; if (busy !== 1'b0)  begin err++; $display("FAIL post_reset_busy got=%0b exp=0", busy); end
  endtask

  task automatic test_corner();
    logic [M-1:0]  a[4];
    logic [M-1:0]  b[4];
    logic [TW-1:0] t[4];
    logic [127:0]  exp;
    a[0] = M'(1) << 52; b[0] = M'(1) << 52; t[0] = 8'h5A;
    a[1] = '1;          b[1] = '1;          t[1] = 8'h33;
    a[2] = '0;          b[2] = M'({$urandom, $urandom}); t[2] = 8'h11;
    a[3] = M'({$urandom, $urandom}); b[3] = '0; t[3] = 8'h22;
    for (int i = 0; i < 4; i++) begin
      exp = ref_prod(128'(a[i]), 128'(b[i]), M);
      op_valid = 1'b1; src1 = a[i]; src2 = b[i]; tag = t[i];
      step();
      op_valid = 1'b0;
      step();
      step();
      chk++; if (rv !== 1'b1) begin err++; $display("FAIL corner%0d_valid got=%0b exp=1", i, rv); end
      chk++; if (rdata !== exp[2*M-1:0])
        begin err++; $display("FAIL corner%0d_data got=%h exp=%h", i, rdata, exp[2*M-1:0]); end
      chk++; if (rsticky !== ref_sticky(exp, M))
        begin err++; $display("FAIL corner%0d_sticky got=%0b exp=%0b", i, rsticky, ref_sticky(exp, M)); end
      chk++; if (rtag !== t[i]) begin err++; $display("FAIL corner%0d_tag got=%h exp=%h", i, rtag, t[i]); end
      step();
      chk++; if (rv !== 1'b0) begin err++; $display("FAIL corner%0d_one_cycle got=%0b exp=0", i, rv); end
    end
  endtask

  task automatic test_throughput();
    logic [M-1:0]  a[20];
    logic [M-1:0]  b[20];
    logic [TW-1:0] t[20];
    logic [127:0]  exp;
    int idx;
    for (int c = 0; c < 23; c++) begin
      if (c < 20) begin
        a[c] = M'({$urandom, $urandom}); b[c] = M'({$urandom, $urandom}); t[c] = 8'($urandom);
        op_valid = 1'b1; src1 = a[c]; src2 = b[c]; tag = t[c];
      end else begin
        op_valid = 1'b0;
      end
      step();
      idx = c - S + 1;
      if (idx >= 0 && idx < 20) begin
        exp = ref_prod(128'(a[idx]), 128'(b[idx]), M);
        chk++; if (rv !== 1'b1) begin err++; $display("FAIL tput%0d_valid got=%0b exp=1", idx, rv); end
        chk++; if (rdata !== exp[2*M-1:0])
          begin err++; $display("FAIL tput%0d_data got=%h exp=%h", idx, rdata, exp[2*M-1:0]); end
        chk++; if (rtag !== t[idx]) begin err++; $display("FAIL tput%0d_tag got=%h exp=%h", idx, rtag, t[idx]); end
      end else if (idx >= 20) begin
        chk++; if (rv !== 1'b0) begin err++; $display("FAIL tput_tail_valid got=%0b exp=0", rv); end
      end
    end
  endtask

  task automatic test_lock();
    logic [2*M-1:0] qd[$];
    logic [TW-1:0]  qt[$];
    logic [127:0]   exp;
    logic [2*M-1:0] snap_d;
    logic [TW-1:0]  snap_t;
    logic           snap_v, was_lock;
    int consumed = 0;
    for (int c = 0; c < 14; c++) begin
      op_valid = (c < 3);
      lock     = (c >= 3 && c <= 6);
      if (c < 3) begin
        src1 = M'({$urandom, $urandom}); src2 = M'({$urandom, $urandom}); tag = 8'($urandom);
        exp = ref_prod(128'(src1), 128'(src2), M);
        qd.push_back(exp[2*M-1:0]); qt.push_back(tag);
      end
      if (rv && !lock) begin
        consumed++;
        chk++;
        if (qd.size() == 0) begin
          err++; $display("FAIL lock_extra_result got=%h exp=none", rdata);
        end else begin
          if (rdata !== qd[0] || rtag !== qt[0]) begin
            err++; $display("FAIL lock_result got=%h/%h exp=%h/%h", rdata, rtag, qd[0], qt[0]);
          end
          void'(qd.pop_front()); void'(qt.pop_front());
        end
      end
      snap_v = rv; snap_t = rtag; snap_d = rdata; was_lock = lock;
      step();
      if (was_lock) begin
        chk++; if ({rv, rtag, rdata} !== {snap_v, snap_t, snap_d})
          begin err++; $display("FAIL lock_frozen cycle=%0d got=%h exp=%h", c, rdata, snap_d); end
      end
    end
    lock = 1'b0;
    chk++; if (consumed !== 3) begin err++; $display("FAIL lock_count got=%0d exp=3", consumed); end
    chk++; if (rv !== 1'b0) begin err++; $display("FAIL lock_drain got=%0b exp=0", rv); end
  endtask

  task automatic test_flush();
    logic [127:0] exp;
    for (int c = 0; c < 3; c++) begin
      op_valid = 1'b1; src1 = M'({$urandom, $urandom}); src2 = M'({$urandom, $urandom});
      tag = 8'($urandom);
      if (c == 2) begin flush = 1'b1; lock = 1'b1; end
      step();
      chk++; if (rv !== 1'b0) begin err++; $display("FAIL flush_pre%0d_valid got=%0b exp=0", c, rv); end
    end
    flush = 1'b0; lock = 1'b0;
    chk++; if (busy !== 1'b0) begin err++; $display("FAIL flush_busy got=%0b exp=0", busy); end
    src1 = M'({$urandom, $urandom}); src2 = M'({$urandom, $urandom}); tag = 8'hC3;
    exp = ref_prod(128'(src1), 128'(src2), M);
    step();
    op_valid = 1'b0;
    chk++; if (rv !== 1'b0) begin err++; $display("FAIL flush_post0_valid got=%0b exp=0", rv); end
    step();
    chk++; if (rv !== 1'b0) begin err++; $display("FAIL flush_post1_valid got=%0b exp=0", rv); end
    step();
    chk++; if (rv !== 1'b1 || rdata !== exp[2*M-1:0] || rtag !== 8'hC3)
      begin err++; $display("FAIL flush_next_op got=%0b/%h/%h exp=1/%h/c3", rv, rdata, rtag, exp[2*M-1:0]); end
    step();
    chk++; if (rv !== 1'b0) begin err++; $display("FAIL flush_after_valid got=%0b exp=0", rv); end
  endtask

  task automatic test_reset_midflight();
    for (int c = 0; c < 3; c++) begin
      op_valid = 1'b1; src1 = M'({$urandom, $urandom}) | M'(1); src2 = M'({$urandom, $urandom}) | M'(1);
      tag = 8'($urandom) | 8'h01;
      step();
    end
    op_valid = 1'b0;
    chk++; if (rv !== 1'b1) begin err++; $display("FAIL midrst_pre_valid got=%0b exp=1", rv); end
    #3;
    rstn = 1'b0;
    #1;
    chk++; if ({rv, rtag, rdata, rsticky, busy} !== '0)
      begin err++; $display("FAIL midrst_outputs got=%0b/%h/%h/%0b/%0b exp=0", rv, rtag, rdata, rsticky, busy); end
    step();
    step();
    rstn = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk++; if (rv !== 1'b0 || busy !== 1'b0)
        begin err++; $display("FAIL midrst_stale%0d got=%0b/%0b exp=0/0", c, rv, busy); end
    end
  endtask

  task automatic test_sweep();
    logic          hv[40];
    logic [63:0]   h1[40];
    logic [63:0]   h2[40];
    logic [TW-1:0] ht[40];
    logic [127:0]  exp;
    int idx;
    for (int c = 0; c < 40; c++) begin
      hv[c] = (c < 30) && ($urandom_range(0, 3) != 0);
      h1[c] = (c == 0) ? '1 : {$urandom, $urandom};
      h2[c] = (c == 0) ? '1 : {$urandom, $urandom};
      ht[c] = 8'($urandom);
      sw_valid = hv[c]; sw_src1 = h1[c]; sw_src2 = h2[c]; sw_tag = ht[c];
      step();
      for (int i = 0; i < NSW; i++) begin
        idx = c - sw_s(i) + 1;
        if (idx >= 0 && hv[idx]) begin
          exp = ref_prod({64'b0, h1[idx]}, {64'b0, h2[idx]}, sw_m(i));
          chk++; if (sw_v[i] !== 1'b1 || sw_d[i] !== exp || sw_t[i] !== ht[idx] ||
                     sw_st[i] !== ref_sticky(exp, sw_m(i)))
            begin err++; $display("FAIL sweep_m%0d_s%0d_op%0d got=%0b/%h/%h exp=1/%h/%h",
                                  sw_m(i), sw_s(i), idx, sw_v[i], sw_d[i], sw_t[i], exp, ht[idx]); end
        end else begin
          chk++; if (sw_v[i] !== 1'b0 || sw_d[i] !== '0 || sw_t[i] !== '0)
            begin err++; $display("FAIL sweep_m%0d_s%0d_idle%0d got=%0b/%h exp=0/0",
                                  sw_m(i), sw_s(i), c, sw_v[i], sw_d[i]); end
        end
      end
    end
    sw_valid = 1'b0;
  endtask

  initial begin
    rstn = 1'b0; lock = 1'b0; flush = 1'b0; op_valid = 1'b0;
    tag = '0; src1 = '0; src2 = '0;
    sw_valid = 1'b0; sw_tag = '0; sw_src1 = '0; sw_src2 = '0;
    test_reset();
    test_corner();
    test_throughput();
    test_lock();
    test_flush();
    test_reset_midflight();
    test_sweep();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule

// File: doc/lagarto_fp_mantissa_mult_pipe.md
# lagarto_fp_mantissa_mult_pipe

Parametrised, pipelined unsigned mantissa multiplier for the Lagarto FPU multiply/FMA datapath. It computes the full 2·MANTISSA-bit product over STAGES pipeline stages by accumulating partial products, one src2 chunk per stage. It carries a sideband tag and produces a rounding sticky bit. It honours the FPU-wide lock (stall) and flush controls, and accepts one operation per cycle when not locked.

## Interface
- MANTISSA, 53: operand width in bits (includes hidden bit); legal range 3..64.
- STAGES, 3: pipeline depth and latency in cycles; legal range 1..8, STAGES ≤ MANTISSA.
- TAG_W, 8: sideband tag width (ROB/lane id), passed through unmodified.
- clk_i  in  1  clock; all state updates on the rising edge.
- rstn_i  in  1  reset, asynchronous, active-low.
- lock_i  in  1  stall: every stage holds its contents.
- flush_i  in  1  kill: every in-flight operation is discarded.
- op_valid_i  in  1  src1_i/src2_i/tag_i are valid this cycle.
- tag_i  in  TAG_W  operation tag.
- src1_i  in  MANTISSA  multiplicand (unsigned).
- src2_i  in  MANTISSA  multiplier (unsigned).
- result_valid_o  out  1  final stage holds a valid product.
- result_tag_o  out  TAG_W  tag of the final-stage operation; 0 when not valid.
- result_data_o  out  2·MANTISSA  product; 0 when not valid.
- result_sticky_o  out  1  OR of product bits [MANTISSA-3:0]; 0 when not valid.
- busy_o  out  1  OR of all stage valid bits.

## Operation
- CHUNK = ceil(MANTISSA/STAGES). Chunk k is src2[k·CHUNK +: CHUNK], truncated at MANTISSA-1. The last chunk may be narrower; chunks beyond the MSB are zero.
- Stage k (0..STAGES-1) holds: valid, tag, src1, src2 (unconsumed high part), and a 2·MANTISSA-bit accumulator.
- Stage 0 loads acc = src1_i · chunk0(src2_i).
- Stage k>0 loads acc = acc[k-1] + (src1[k-1] · chunk_k(src2[k-1]) << k·CHUNK). All arithmetic is unsigned. The accumulator never overflows 2·MANTISSA bits.
- The final stage's acc is the exact product src1·src2. STAGES=1 degenerates to a single registered multiply.
- Payload registers (tag, src1, src2, acc) update only when the incoming valid is 1; bubbles advance only the valid bit. Outputs are gated to 0 when result_valid_o=0.
- Control priority per cycle: reset > flush_i > lock_i > advance.
  - Flush: all valid bits and payload registers cleared to 0. An op_valid_i presented in the same cycle is dropped.
  - Lock: every register holds, including the final stage, so result_* stays stable. An op_valid_i presented while locked is not captured; the upstream unit must hold it.
  - Advance: stage k captures stage k-1; stage 0 captures the inputs.
- result_sticky_o is computed combinationally from the final-stage accumulator.
- There is no internal FSM beyond the per-stage valid shift; the pipeline is the state.

## Timing
- Reset: all valid bits 0; all payload registers 0; result_valid_o=0, result_tag_o=0, result_data_o=0, result_sticky_o=0, busy_o=0.
- Latency: an op accepted at edge N (op_valid_i=1, lock_i=0, flush_i=0) appears on result_* after edge N+STAGES-1, i.e. STAGES cycles later, plus one cycle per locked cycle in flight.
- Throughput: 1 op/cycle; back-to-back ops emerge on consecutive cycles in order.
- result_valid_o is asserted for exactly one cycle per op, unless lock_i holds it longer. The consumer samples whenever result_valid_o=1 and lock_i=0.
- Reset asserted mid-operation: all state clears immediately (asynchronous). No result is ever produced for ops in flight.
- Flush and lock asserted together: flush wins.
- Critical path: one MANTISSA×CHUNK multiply plus a 2·MANTISSA add per stage.

## Test plan
- Corner operands (MANTISSA=53, STAGES=3, CHUNK=18):
  - src1=src2=2^52, tag=0x5A → after 3 cycles data=2^104 (bit 104 set, bit 105 clear), sticky=0, tag=0x5A.
  - src1=src2=2^53-1 → data=2^106-2^54+1, sticky=1, bit 105 set.
  - src1=0 or src2=0 → data=0, sticky=0, valid=1.
- Throughput: 20 consecutive random ops with op_valid_i=1 → 20 consecutive valid results in order, each equal to the reference product and tag.
- Lock: issue ops A,B,C on consecutive cycles, assert lock_i for 4 cycles after B enters stage 1 → outputs frozen during lock, no op lost or duplicated, A/B/C each emerge exactly once with correct values.
- Flush: issue 3 ops, assert flush_i for one cycle with a new op_valid_i and lock_i=1 → busy_o=0 next cycle, no result_valid_o for any of those ops, the next op after flush returns correctly 3 cycles later.
- Reset mid-flight: deassert rstn_i asynchronously between edges with 2 ops in flight → all outputs 0 immediately, no stale result after release.
- Parameter sweep: MANTISSA∈{11,24,53}, STAGES∈{1,2,4} with random operands → exact product, latency = STAGES cycles, STAGES=1 matches a single registered multiply cycle for cycle.
